// File: rtl/hnoc_fabric.sv
// hnoc_fabric: 16-PE hierarchical NoC for single-flit packets.
// Four clusters of four PEs. Each cluster has a 5x5 local switch: 4 PE ports plus one uplink/downlink.
// A 4x4 top switch joins the four cluster uplinks.
// Every switch output is a one-entry register with its own round-robin arbiter.
// Optional feature: define HNOC_DELIVERY_COUNT_EN to add o_delivered_count.
// That output is a wrapping count of flits handed to the PEs.
module hnoc_fabric #(
    parameter int DATA_W   = 32,
    parameter int DEST_LSB = 28
) (
    input  logic              clk,
    input  logic              rst,
`ifdef HNOC_DELIVERY_COUNT_EN
    output logic [31:0]       o_delivered_count,
`endif
    input  logic [DATA_W-1:0] i_pe_data0,  input  logic i_pe_data_valid0,  input  logic i_pe_data_ready0,
    output logic [DATA_W-1:0] o_pe_data0,  output logic o_pe_data_valid0,  output logic o_pe_data_ready0,
    input  logic [DATA_W-1:0] i_pe_data1,  input  logic i_pe_data_valid1,  input  logic i_pe_data_ready1,
    output logic [DATA_W-1:0] o_pe_data1,  output logic o_pe_data_valid1,  output logic o_pe_data_ready1,
    input  logic [DATA_W-1:0] i_pe_data2,  input  logic i_pe_data_valid2,  input  logic i_pe_data_ready2,
    output logic [DATA_W-1:0] o_pe_data2,  output logic o_pe_data_valid2,  output logic o_pe_data_ready2,
    input  logic [DATA_W-1:0] i_pe_data3,  input  logic i_pe_data_valid3,  input  logic i_pe_data_ready3,
    output logic [DATA_W-1:0] o_pe_data3,  output logic o_pe_data_valid3,  output logic o_pe_data_ready3,
    input  logic [DATA_W-1:0] i_pe_data4,  input  logic i_pe_data_valid4,  input  logic i_pe_data_ready4,
    output logic [DATA_W-1:0] o_pe_data4,  output logic o_pe_data_valid4,  output logic o_pe_data_ready4,
    input  logic [DATA_W-1:0] i_pe_data5,  input  logic i_pe_data_valid5,  input  logic i_pe_data_ready5,
    output logic [DATA_W-1:0] o_pe_data5,  output logic o_pe_data_valid5,  output logic o_pe_data_ready5,
    input  logic [DATA_W-1:0] i_pe_data6,  input  logic i_pe_data_valid6,  input  logic i_pe_data_ready6,
    output logic [DATA_W-1:0] o_pe_data6,  output logic o_pe_data_valid6,  output logic o_pe_data_ready6,
    input  logic [DATA_W-1:0] i_pe_data7,  input  logic i_pe_data_valid7,  input  logic i_pe_data_ready7,
    output logic [DATA_W-1:0] o_pe_data7,  output logic o_pe_data_valid7,  output logic o_pe_data_ready7,
    input  logic [DATA_W-1:0] i_pe_data8,  input  logic i_pe_data_valid8,  input  logic i_pe_data_ready8,
    output logic [DATA_W-1:0] o_pe_data8,  output logic o_pe_data_valid8,  output logic o_pe_data_ready8,
    input  logic [DATA_W-1:0] i_pe_data9,  input  logic i_pe_data_valid9,  input  logic i_pe_data_ready9,
    output logic [DATA_W-1:0] o_pe_data9,  output logic o_pe_data_valid9,  output logic o_pe_data_ready9,
    input  logic [DATA_W-1:0] i_pe_data10, input  logic i_pe_data_valid10, input  logic i_pe_data_ready10,
    output logic [DATA_W-1:0] o_pe_data10, output logic o_pe_data_valid10, output logic o_pe_data_ready10,
    input  logic [DATA_W-1:0] i_pe_data11, input  logic i_pe_data_valid11, input  logic i_pe_data_ready11,
    output logic [DATA_W-1:0] o_pe_data11, output logic o_pe_data_valid11, output logic o_pe_data_ready11,
    input  logic [DATA_W-1:0] i_pe_data12, input  logic i_pe_data_valid12, input  logic i_pe_data_ready12,
    output logic [DATA_W-1:0] o_pe_data12, output logic o_pe_data_valid12, output logic o_pe_data_ready12,
    input  logic [DATA_W-1:0] i_pe_data13, input  logic i_pe_data_valid13, input  logic i_pe_data_ready13,
    output logic [DATA_W-1:0] o_pe_data13, output logic o_pe_data_valid13, output logic o_pe_data_ready13,
    input  logic [DATA_W-1:0] i_pe_data14, input  logic i_pe_data_valid14, input  logic i_pe_data_ready14,
    output logic [DATA_W-1:0] o_pe_data14, output logic o_pe_data_valid14, output logic o_pe_data_ready14,
    input  logic [DATA_W-1:0] i_pe_data15, input  logic i_pe_data_valid15, input  logic i_pe_data_ready15,
    output logic [DATA_W-1:0] o_pe_data15, output logic o_pe_data_valid15, output logic o_pe_data_ready15
);

    localparam int NPE = 16;
    localparam int NCL = 4;

    logic [NPE-1:0][DATA_W-1:0] pe_in_data;
    logic [NPE-1:0]             pe_in_vld;
    logic [NPE-1:0]             pe_dst_rdy;
    logic [NPE-1:0]             pe_rdy;

    logic [NPE-1:0][DATA_W-1:0] pe_data_q, pe_data_d;
    logic [NPE-1:0]             pe_vld_q, pe_vld_d;
    logic [NPE-1:0][2:0]        pe_ptr_q, pe_ptr_d;
    logic [NCL-1:0][DATA_W-1:0] up_data_q, up_data_d;
    logic [NCL-1:0]             up_vld_q, up_vld_d;
    logic [NCL-1:0][2:0]        up_ptr_q, up_ptr_d;
    logic [NCL-1:0][DATA_W-1:0] dn_data_q, dn_data_d;
    logic [NCL-1:0]             dn_vld_q, dn_vld_d;
    logic [NCL-1:0][1:0]        dn_ptr_q, dn_ptr_d;

    logic [NPE-1:0] grant_local, grant_up;
    logic [NCL-1:0] dn_drain, up_drain;
    logic [4:0]     l_req, t_req, u_req;
    logic [3:0]     l_pick, t_pick, u_pick;
    logic           l_fire, t_fire, u_fire;

    assign pe_in_data = {i_pe_data15, i_pe_data14, i_pe_data13, i_pe_data12, i_pe_data11, i_pe_data10,
                         i_pe_data9, i_pe_data8, i_pe_data7, i_pe_data6, i_pe_data5, i_pe_data4,
                         i_pe_data3, i_pe_data2, i_pe_data1, i_pe_data0};
    assign pe_in_vld  = {i_pe_data_valid15, i_pe_data_valid14, i_pe_data_valid13, i_pe_data_valid12,
                         i_pe_data_valid11, i_pe_data_valid10, i_pe_data_valid9, i_pe_data_valid8,
                         i_pe_data_valid7, i_pe_data_valid6, i_pe_data_valid5, i_pe_data_valid4,
                         i_pe_data_valid3, i_pe_data_valid2, i_pe_data_valid1, i_pe_data_valid0};
    assign pe_dst_rdy = {i_pe_data_ready15, i_pe_data_ready14, i_pe_data_ready13, i_pe_data_ready12,
                         i_pe_data_ready11, i_pe_data_ready10, i_pe_data_ready9, i_pe_data_ready8,
                         i_pe_data_ready7, i_pe_data_ready6, i_pe_data_ready5, i_pe_data_ready4,
                         i_pe_data_ready3, i_pe_data_ready2, i_pe_data_ready1, i_pe_data_ready0};

    assign {o_pe_data15, o_pe_data14, o_pe_data13, o_pe_data12, o_pe_data11, o_pe_data10,
            o_pe_data9, o_pe_data8, o_pe_data7, o_pe_data6, o_pe_data5, o_pe_data4,
            o_pe_data3, o_pe_data2, o_pe_data1, o_pe_data0} = pe_data_q;
    assign {o_pe_data_valid15, o_pe_data_valid14, o_pe_data_valid13, o_pe_data_valid12,
            o_pe_data_valid11, o_pe_data_valid10, o_pe_data_valid9, o_pe_data_valid8,
            o_pe_data_valid7, o_pe_data_valid6, o_pe_data_valid5, o_pe_data_valid4,
            o_pe_data_valid3, o_pe_data_valid2, o_pe_data_valid1, o_pe_data_valid0} = pe_vld_q;
    assign {o_pe_data_ready15, o_pe_data_ready14, o_pe_data_ready13, o_pe_data_ready12,
            o_pe_data_ready11, o_pe_data_ready10, o_pe_data_ready9, o_pe_data_ready8,
            o_pe_data_ready7, o_pe_data_ready6, o_pe_data_ready5, o_pe_data_ready4,
            o_pe_data_ready3, o_pe_data_ready2, o_pe_data_ready1, o_pe_data_ready0} = pe_rdy;

    // Round-robin pick over n requesters starting at ptr; returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr, input int n);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        // Walk from the farthest offset down so the closest requester to ptr wins last.
        for (int k = 4; k >= 0; k--) begin
            if (k < n) begin
                idx = 3'((int'(ptr) + k) % n);
                if (req[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Local switch PE outputs: arbitrate 4 PE inputs plus the cluster downlink into each PE register.
    always_comb begin
        pe_data_d   = pe_data_q;
        pe_vld_d    = pe_vld_q;
        pe_ptr_d    = pe_ptr_q;
        grant_local = '0;
        dn_drain    = '0;
        l_req       = '0;
        l_pick      = '0;
        l_fire      = 1'b0;
        for (int o = 0; o < NPE; o++) begin
            l_req = '0;
            for (int k = 0; k < 4; k++) begin
                l_req[k] = pe_in_vld[(o/4)*4+k] &&
                           (pe_in_data[(o/4)*4+k][DEST_LSB+3:DEST_LSB] == 4'(o));
            end
            l_req[4] = dn_vld_q[o/4] && (dn_data_q[o/4][DEST_LSB+1:DEST_LSB] == 2'(o % 4));
            l_pick   = rr_pick(l_req, pe_ptr_q[o], 5);
            l_fire   = l_pick[3] && (!pe_vld_q[o] || pe_dst_rdy[o]);
            pe_vld_d[o] = pe_vld_q[o] && !pe_dst_rdy[o];
            if (l_fire) begin
                pe_vld_d[o] = 1'b1;
                pe_ptr_d[o] = (l_pick[2:0] == 3'd4) ? 3'd0 : l_pick[2:0] + 3'd1;
                if (l_pick[2:0] == 3'd4) begin
                    pe_data_d[o]   = dn_data_q[o/4];
                    dn_drain[o/4]  = 1'b1;
                end
                for (int k = 0; k < 4; k++) begin
                    if (l_pick[2:0] == 3'(k)) begin
                        pe_data_d[o]              = pe_in_data[(o/4)*4+k];
                        grant_local[(o/4)*4+k]    = 1'b1;
                    end
                end
            end
        end
    end

    // Top switch: route uplinks to downlink registers by destination cluster.
    always_comb begin
        dn_data_d = dn_data_q;
        dn_vld_d  = dn_vld_q;
        dn_ptr_d  = dn_ptr_q;
        up_drain  = '0;
        t_req     = '0;
        t_pick    = '0;
        t_fire    = 1'b0;
        for (int d = 0; d < NCL; d++) begin
            t_req = '0;
            for (int u = 0; u < NCL; u++) begin
                t_req[u] = up_vld_q[u] && (up_data_q[u][DEST_LSB+3:DEST_LSB+2] == 2'(d));
            end
            t_pick      = rr_pick(t_req, {1'b0, dn_ptr_q[d]}, 4);
            t_fire      = t_pick[3] && (!dn_vld_q[d] || dn_drain[d]);
            dn_vld_d[d] = dn_vld_q[d] && !dn_drain[d];
            if (t_fire) begin
                dn_vld_d[d] = 1'b1;
                dn_ptr_d[d] = t_pick[1:0] + 2'd1;
                for (int u = 0; u < NCL; u++) begin
                    if (t_pick[2:0] == 3'(u)) begin
                        dn_data_d[d] = up_data_q[u];
                        up_drain[u]  = 1'b1;
                    end
                end
            end
        end
    end

    // Local switch uplinks: collect off-cluster flits from the cluster's PEs.
    always_comb begin
        up_data_d = up_data_q;
        up_vld_d  = up_vld_q;
        up_ptr_d  = up_ptr_q;
        grant_up  = '0;
        u_req     = '0;
        u_pick    = '0;
        u_fire    = 1'b0;
        for (int c = 0; c < NCL; c++) begin
            u_req = '0;
            for (int k = 0; k < 4; k++) begin
                u_req[k] = pe_in_vld[c*4+k] && (pe_in_data[c*4+k][DEST_LSB+3:DEST_LSB+2] != 2'(c));
            end
            u_pick      = rr_pick(u_req, up_ptr_q[c], 5);
            u_fire      = u_pick[3] && (!up_vld_q[c] || up_drain[c]);
            up_vld_d[c] = up_vld_q[c] && !up_drain[c];
            if (u_fire) begin
                up_vld_d[c] = 1'b1;
                up_ptr_d[c] = (u_pick[2:0] == 3'd4) ? 3'd0 : u_pick[2:0] + 3'd1;
                for (int k = 0; k < 4; k++) begin
                    if (u_pick[2:0] == 3'(k)) begin
                        up_data_d[c]     = pe_in_data[c*4+k];
                        grant_up[c*4+k]  = 1'b1;
                    end
                end
            end
        end
    end

    // A PE is ready only when it won the output it targets; nothing is accepted during reset.
    assign pe_rdy = (grant_local | grant_up) & {NPE{!rst}};

    // State registers; reset drops every in-flight flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_data_q <= '0;
            pe_vld_q  <= '0;
            pe_ptr_q  <= '0;
            up_data_q <= '0;
            up_vld_q  <= '0;
            up_ptr_q  <= '0;
            dn_data_q <= '0;
            dn_vld_q  <= '0;
            dn_ptr_q  <= '0;
        end else begin
            pe_data_q <= pe_data_d;
            pe_vld_q  <= pe_vld_d;
            pe_ptr_q  <= pe_ptr_d;
            up_data_q <= up_data_d;
            up_vld_q  <= up_vld_d;
            up_ptr_q  <= up_ptr_d;
            dn_data_q <= dn_data_d;
            dn_vld_q  <= dn_vld_d;
            dn_ptr_q  <= dn_ptr_d;
        end
    end

`ifdef HNOC_DELIVERY_COUNT_EN
    logic [31:0] dcnt_q, dcnt_d;

    // Add this cycle's completed PE deliveries; wraps naturally at 2^32.
    always_comb begin
        dcnt_d = dcnt_q + 32'($countones(pe_vld_q & pe_dst_rdy));
    end

    // Delivery counter register.
    always_ff @(posedge clk) begin
        if (rst) dcnt_q <= '0;
        else     dcnt_q <= dcnt_d;
    end

    assign o_delivered_count = dcnt_q;
`endif

endmodule

// File: tb/tb_hnoc_fabric.sv
// Directed testbench for hnoc_fabric.
// Covers intra- and inter-cluster routing, contention, back-pressure, reset and all-to-all traffic.
// The delivery counter is checked when HNOC_DELIVERY_COUNT_EN is defined.
module tb_hnoc_fabric;

    logic              clk;
    logic              rst;
    logic [15:0][31:0] in_data;
    logic [15:0]       in_vld;
    logic [15:0]       dst_rdy;
    wire  [15:0][31:0] out_data;
    wire  [15:0]       out_vld;
    wire  [15:0]       o_rdy;
`ifdef HNOC_DELIVERY_COUNT_EN
    wire  [31:0]       dcount;
`endif

    int checks = 0;
    int errors = 0;

    hnoc_fabric dut (
        .clk(clk), .rst(rst),
`ifdef HNOC_DELIVERY_COUNT_EN
        .o_delivered_count(dcount),
`endif
        .i_pe_data0(in_data[0]),   .i_pe_data_valid0(in_vld[0]),   .i_pe_data_ready0(dst_rdy[0]),
        .o_pe_data0(out_data[0]),  .o_pe_data_valid0(out_vld[0]),  .o_pe_data_ready0(o_rdy[0]),
        .i_pe_data1(in_data[1]),   .i_pe_data_valid1(in_vld[1]),   .i_pe_data_ready1(dst_rdy[1]),
        .o_pe_data1(out_data[1]),  .o_pe_data_valid1(out_vld[1]),  .o_pe_data_ready1(o_rdy[1]),
        .i_pe_data2(in_data[2]),   .i_pe_data_valid2(in_vld[2]),   .i_pe_data_ready2(dst_rdy[2]),
        .o_pe_data2(out_data[2]),  .o_pe_data_valid2(out_vld[2]),  .o_pe_data_ready2(o_rdy[2]),
        .i_pe_data3(in_data[3]),   .i_pe_data_valid3(in_vld[3]),   .i_pe_data_ready3(dst_rdy[3]),
        .o_pe_data3(out_data[3]),  .o_pe_data_valid3(out_vld[3]),  .o_pe_data_ready3(o_rdy[3]),
        .i_pe_data4(in_data[4]),   .i_pe_data_valid4(in_vld[4]),   .i_pe_data_ready4(dst_rdy[4]),
        .o_pe_data4(out_data[4]),  .o_pe_data_valid4(out_vld[4]),  .o_pe_data_ready4(o_rdy[4]),
        .i_pe_data5(in_data[5]),   .i_pe_data_valid5(in_vld[5]),   .i_pe_data_ready5(dst_rdy[5]),
        .o_pe_data5(out_data[5]),  .o_pe_data_valid5(out_vld[5]),  .o_pe_data_ready5(o_rdy[5]),
        .i_pe_data6(in_data[6]),   .i_pe_data_valid6(in_vld[6]),   .i_pe_data_ready6(dst_rdy[6]),
        .o_pe_data6(out_data[6]),  .o_pe_data_valid6(out_vld[6]),  .o_pe_data_ready6(o_rdy[6]),
        .i_pe_data7(in_data[7]),   .i_pe_data_valid7(in_vld[7]),   .i_pe_data_ready7(dst_rdy[7]),
        .o_pe_data7(out_data[7]),  .o_pe_data_valid7(out_vld[7]),  .o_pe_data_ready7(o_rdy[7]),
        .i_pe_data8(in_data[8]),   .i_pe_data_valid8(in_vld[8]),   .i_pe_data_ready8(dst_rdy[8]),
        .o_pe_data8(out_data[8]),  .o_pe_data_valid8(out_vld[8]),  .o_pe_data_ready8(o_rdy[8]),
        .i_pe_data9(in_data[9]),   .i_pe_data_valid9(in_vld[9]),   .i_pe_data_ready9(dst_rdy[9]),
        .o_pe_data9(out_data[9]),  .o_pe_data_valid9(out_vld[9]),  .o_pe_data_ready9(o_rdy[9]),
        .i_pe_data10(in_data[10]), .i_pe_data_valid10(in_vld[10]), .i_pe_data_ready10(dst_rdy[10]),
        .o_pe_data10(out_data[10]), .o_pe_data_valid10(out_vld[10]), .o_pe_data_ready10(o_rdy[10]),
        .i_pe_data11(in_data[11]), .i_pe_data_valid11(in_vld[11]), .i_pe_data_ready11(dst_rdy[11]),
        .o_pe_data11(out_data[11]), .o_pe_data_valid11(out_vld[11]), .o_pe_data_ready11(o_rdy[11]),
        .i_pe_data12(in_data[12]), .i_pe_data_valid12(in_vld[12]), .i_pe_data_ready12(dst_rdy[12]),
        .o_pe_data12(out_data[12]), .o_pe_data_valid12(out_vld[12]), .o_pe_data_ready12(o_rdy[12]),
        .i_pe_data13(in_data[13]), .i_pe_data_valid13(in_vld[13]), .i_pe_data_ready13(dst_rdy[13]),
        .o_pe_data13(out_data[13]), .o_pe_data_valid13(out_vld[13]), .o_pe_data_ready13(o_rdy[13]),
        .i_pe_data14(in_data[14]), .i_pe_data_valid14(in_vld[14]), .i_pe_data_ready14(dst_rdy[14]),
        .o_pe_data14(out_data[14]), .o_pe_data_valid14(out_vld[14]), .o_pe_data_ready14(o_rdy[14]),
        .i_pe_data15(in_data[15]), .i_pe_data_valid15(in_vld[15]), .i_pe_data_ready15(dst_rdy[15]),
        .o_pe_data15(out_data[15]), .o_pe_data_valid15(out_vld[15]), .o_pe_data_ready15(o_rdy[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] acc;
        logic [15:0] seen;
        int          delivered;

        in_data = '0;
        in_vld  = '1;
        dst_rdy = '1;
        rst     = 1'b1;
        cyc();
        cyc();
        chk("rst_rdy", 32'(o_rdy), 32'h0);
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_data5", out_data[5], 32'h0);
        in_vld = '0;
        rst    = 1'b0;
        cyc();

        // intra-cluster PE1 -> PE3
        in_data[1] = 32'h3000_00AA;
        in_vld[1]  = 1'b1;
        #1;
        chk("t1_rdy", 32'(o_rdy[1]), 32'h1);
        cyc();
        in_vld[1] = 1'b0;
        chk("t1_vld", 32'(out_vld), 32'h0008);
        chk("t1_data", out_data[3], 32'h3000_00AA);
        cyc();
        chk("t1_once", 32'(out_vld), 32'h0);

        // inter-cluster PE0 -> PE15, three edges
        in_data[0] = 32'hF000_1234;
        in_vld[0]  = 1'b1;
        #1;
        chk("t2_rdy", 32'(o_rdy[0]), 32'h1);
        cyc();
        in_vld[0] = 1'b0;
        chk("t2_e1", 32'(out_vld), 32'h0);
        cyc();
        chk("t2_e2", 32'(out_vld), 32'h0);
        cyc();
        chk("t2_e3_vld", 32'(out_vld), 32'h8000);
        chk("t2_e3_data", out_data[15], 32'hF000_1234);
        cyc();
        chk("t2_after", 32'(out_vld), 32'h0);

        // contention PE4,5,6 -> PE7
        in_data[4] = 32'h7000_0004;
        in_data[5] = 32'h7000_0005;
        in_data[6] = 32'h7000_0006;
        in_vld[6:4] = 3'b111;
        #1;
        chk("t3_rdy_a", 32'(o_rdy[7:4]), 32'h1);
        cyc();
        in_vld[4] = 1'b0;
        chk("t3_vld_a", 32'(out_vld), 32'h0080);
        chk("t3_data_a", out_data[7], 32'h7000_0004);
        #1;
        chk("t3_rdy_b", 32'(o_rdy[7:4]), 32'h2);
        cyc();
        in_vld[5] = 1'b0;
        chk("t3_data_b", out_data[7], 32'h7000_0005);
        cyc();
        in_vld[6] = 1'b0;
        chk("t3_data_c", out_data[7], 32'h7000_0006);
        cyc();
        chk("t3_idle", 32'(out_vld), 32'h0);
        in_data[7]  = 32'h7000_0007;
        in_vld[7:4] = 4'hF;
        #1;
        chk("t3_round2", 32'(o_rdy[7:4]), 32'h8);
        in_vld = '0;

        // back-pressure on PE2 while PE0 streams three flits
        cyc();
        dst_rdy[2] = 1'b0;
        in_data[0] = 32'h2000_0001;
        in_vld[0]  = 1'b1;
        #1;
        chk("t4_rdy_a", 32'(o_rdy[0]), 32'h1);
        cyc();
        in_data[0] = 32'h2000_0002;
        #1;
        chk("t4_stall_rdy", 32'(o_rdy[0]), 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t4_hold_data", out_data[2], 32'h2000_0001);
            chk("t4_hold_vld", 32'(out_vld), 32'h0004);
            chk("t4_hold_rdy", 32'(o_rdy[0]), 32'h0);
        end
        dst_rdy[2] = 1'b1;
        #1;
        chk("t4_release_rdy", 32'(o_rdy[0]), 32'h1);
        cyc();
        in_data[0] = 32'h2000_0003;
        chk("t4_data_b", out_data[2], 32'h2000_0002);
        chk("t4_vld_b", 32'(out_vld), 32'h0004);
        #1;
        chk("t4_rdy_c", 32'(o_rdy[0]), 32'h1);
        cyc();
        in_vld[0] = 1'b0;
        chk("t4_data_c", out_data[2], 32'h2000_0003);
        chk("t4_vld_c", 32'(out_vld), 32'h0004);
        cyc();
        chk("t4_done", 32'(out_vld), 32'h0);

        // self-addressed PE9 -> PE9
        in_data[9] = 32'h9000_0009;
        in_vld[9]  = 1'b1;
        #1;
        chk("t6_rdy", 32'(o_rdy[9]), 32'h1);
        cyc();
        in_vld[9] = 1'b0;
        chk("t6_vld", 32'(out_vld), 32'h0200);
        chk("t6_data", out_data[9], 32'h9000_0009);
        cyc();

        // reset with four inter-cluster flits in flight
        in_data[0]  = 32'hF000_0000;
        in_data[4]  = 32'h0000_0004;
        in_data[8]  = 32'h5000_0008;
        in_data[12] = 32'hA000_000C;
        in_vld      = 16'h1111;
        #1;
        chk("t5_accept", 32'(o_rdy), 32'h1111);
        cyc();
        in_vld = '0;
        cyc();
        chk("t5_inflight", 32'(out_vld), 32'h0);
        rst = 1'b1;
        cyc();
        chk("t5_rst_vld", 32'(out_vld), 32'h0);
        in_vld = '1;
        #1;
        chk("t5_rst_rdy", 32'(o_rdy), 32'h0);
        in_vld = '0;
        rst    = 1'b0;
        seen   = '0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            seen = seen | out_vld;
        end
        chk("t5_no_stale", 32'(seen), 32'h0);

        // all-to-all: PE n -> PE (n+5)%16
        for (int n = 0; n < 16; n++) in_data[n] = {4'((n + 5) % 16), 4'(n), 24'hC0FFEE};
        in_vld    = '1;
        delivered = 0;
        for (int cy = 0; cy < 40; cy++) begin
            #1;
            acc = in_vld & o_rdy;
            cyc();
            in_vld = in_vld & ~acc;
            for (int d = 0; d < 16; d++) begin
                if (out_vld[d]) begin
                    chk("a2a_data", out_data[d], {4'(d), 4'((d + 11) % 16), 24'hC0FFEE});
                    delivered++;
                end
            end
        end
        chk("a2a_count", 32'(delivered), 32'd16);
        chk("a2a_pending", 32'(in_vld), 32'h0);
`ifdef HNOC_DELIVERY_COUNT_EN
        chk("dcount", dcount, 32'd16);
        for (int i = 0; i < 5; i++) cyc();
        chk("dcount_stable", dcount, 32'd16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
